// File: rtl/sdram_responder.sv
// rtl/sdram_responder.sv - SDR SDRAM device-side responder (16-bit, 4 banks) with CAS-latency read pipeline
// Define SDRAM_RESP_TIMING_CHECK_EN to build per-bank TRCD/TRP checkers that drive err[1].
module sdram_responder #(
    parameter int MEM_AW   = 14,
    parameter int COL_BITS = 9,
    parameter int TRCD     = 2,
    parameter int TRP      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [1:0]  sd_ba,
    input  logic [12:0] sd_a,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic        sd_dq_oe,
    output logic        mode_valid,
    output logic [1:0]  cas_lat,
    output logic [15:0] refresh_cnt,
    output logic [3:0]  err
);

    localparam int AW_FULL = 2 + 13 + COL_BITS;

    logic [2:0] cmd;
    logic       is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;

    always_comb begin
        cmd    = sd_ncs ? 3'b111 : {sd_nras, sd_ncas, sd_nwe};
        is_act = 1'b0;
        is_rd  = 1'b0;
        is_wr  = 1'b0;
        is_pre = 1'b0;
        is_ref = 1'b0;
        is_lmr = 1'b0;
        case (cmd)
            3'b011:  is_act = 1'b1;
            3'b101:  is_rd  = 1'b1;
            3'b100:  is_wr  = 1'b1;
            3'b010:  is_pre = 1'b1;
            3'b001:  is_ref = 1'b1;
            3'b000:  is_lmr = 1'b1;
            default: ;
        endcase
    end

    logic [3:0]          bank_open;
    logic [12:0]         open_row [4];
    logic                all_closed;
    logic                sel_open;
    logic                is_access;
    logic                do_rd, do_wr, do_access;
    logic                auto_pre;
    logic [AW_FULL-1:0]  full_addr;
    logic [MEM_AW-1:0]   mem_addr;

    assign all_closed = (bank_open == 4'b0000);
    assign sel_open   = bank_open[sd_ba];
    assign is_access  = is_rd || is_wr;
    assign do_rd      = is_rd && sel_open;
    assign do_wr      = is_wr && sel_open;
    assign do_access  = do_rd || do_wr;
    assign auto_pre   = sd_a[10];
    assign full_addr  = {sd_ba, open_row[sd_ba], sd_a[COL_BITS-1:0]};
    assign mem_addr   = full_addr[MEM_AW-1:0];

    logic unused_addr_bits;
    assign unused_addr_bits = ^full_addr[AW_FULL-1:MEM_AW];

    // Auto-precharge closes the bank on the access edge itself, so a later ACTIVE sees CLOSED.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_open <= '0;
            for (int b = 0; b < 4; b++) open_row[b] <= '0;
        end else if (is_act) begin
            bank_open[sd_ba] <= 1'b1;
            open_row[sd_ba]  <= sd_a;
        end else if (do_access && auto_pre) begin
            bank_open[sd_ba] <= 1'b0;
        end else if (is_pre) begin
            if (sd_a[10]) bank_open <= '0;
            else          bank_open[sd_ba] <= 1'b0;
        end
    end

    logic [15:0] mem [2**MEM_AW];
    logic [15:0] mem_word;

    assign mem_word = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            if (!sd_dqml) mem[mem_addr][7:0]  <= sd_dq_in[7:0];
            if (!sd_dqmh) mem[mem_addr][15:8] <= sd_dq_in[15:8];
        end
    end

    // Stage 0 holds every read for one cycle; CL=3 reads take one extra hop through stage 1.
    logic        rd_v0, rd_late0, rd_v1;
    logic [15:0] rd_d0, rd_d1;
    logic        rd_fire;
    logic [15:0] rd_fire_data;

    assign rd_fire      = rd_v1 || (rd_v0 && !rd_late0);
    assign rd_fire_data = rd_v1 ? rd_d1 : rd_d0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v0     <= 1'b0;
            rd_late0  <= 1'b0;
            rd_d0     <= '0;
            rd_v1     <= 1'b0;
            rd_d1     <= '0;
            sd_dq_oe  <= 1'b0;
            sd_dq_out <= '0;
        end else begin
            rd_v0     <= do_rd;
            rd_late0  <= (cas_lat == 2'd3);
            rd_d0     <= {sd_dqmh ? 8'h00 : mem_word[15:8], sd_dqml ? 8'h00 : mem_word[7:0]};
            rd_v1     <= rd_v0 && rd_late0;
            rd_d1     <= rd_d0;
            sd_dq_oe  <= rd_fire;
            sd_dq_out <= rd_fire ? rd_fire_data : 16'h0000;
        end
    end

    logic       lm_cl_ok, lm_burst_ok;
    logic       row_viol, mode_viol, proto_viol;
    logic       err_row, err_timing, err_mode, err_proto;

    assign lm_cl_ok    = (sd_a[6:4] == 3'd2) || (sd_a[6:4] == 3'd3);
    assign lm_burst_ok = (sd_a[2:0] == 3'd0);
    assign row_viol    = (is_act && sel_open) || (is_access && !sel_open) ||
                         ((is_ref || is_lmr) && !all_closed);
    assign mode_viol   = is_access && !mode_valid;
    // Contention covers the bus already being driven and the pulse being launched on this edge.
    assign proto_viol  = (is_lmr && all_closed && !(lm_cl_ok && lm_burst_ok)) ||
                         (is_wr && (sd_dq_oe || rd_fire));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_valid  <= 1'b0;
            cas_lat     <= 2'd2;
            refresh_cnt <= '0;
            err_row     <= 1'b0;
            err_mode    <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            if (is_ref) refresh_cnt <= refresh_cnt + 16'd1;
            if (is_lmr && all_closed) begin
                if (lm_cl_ok)                mode_valid <= mode_valid;
                if (lm_cl_ok)                cas_lat    <= sd_a[5:4];
                if (lm_cl_ok && lm_burst_ok) mode_valid <= 1'b1;
            end
            if (row_viol)   err_row   <= 1'b1;
            if (mode_viol)  err_mode  <= 1'b1;
            if (proto_viol) err_proto <= 1'b1;
        end
    end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    localparam int TW = 8;
    localparam logic [TW-1:0] TSAT = '1;

    // Counters hold the number of edges since the last ACTIVE / precharge of each bank.
    logic [TW-1:0] trcd_cnt [4];
    logic [TW-1:0] trp_cnt  [4];
    logic          timing_viol;

    always_comb begin
        timing_viol = 1'b0;
        if (do_access && (trcd_cnt[sd_ba] < TW'(TRCD))) timing_viol = 1'b1;
        if (is_act && (trp_cnt[sd_ba] < TW'(TRP)))      timing_viol = 1'b1;
        if (is_ref) begin
            for (int b = 0; b < 4; b++) begin
                if (trp_cnt[b] < TW'(TRP)) timing_viol = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                trcd_cnt[b] <= TSAT;
                trp_cnt[b]  <= TSAT;
            end
            err_timing <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (is_act && (sd_ba == 2'(b)))  trcd_cnt[b] <= TW'(1);
                else if (trcd_cnt[b] != TSAT)    trcd_cnt[b] <= trcd_cnt[b] + TW'(1);
                if ((is_pre && (sd_a[10] || (sd_ba == 2'(b)))) ||
                    (do_access && auto_pre && (sd_ba == 2'(b))))
                    trp_cnt[b] <= TW'(1);
                else if (trp_cnt[b] != TSAT)
                    trp_cnt[b] <= trp_cnt[b] + TW'(1);
            end
            if (timing_viol) err_timing <= 1'b1;
        end
    end
`else
    logic unused_timing;
    assign unused_timing = ^{32'(TRCD), 32'(TRP)};
    assign err_timing    = 1'b0;
`endif

    assign err = {err_proto, err_mode, err_timing, err_row};

endmodule
